instr_fetch: RTL and testbench

//  Instruction fetch stage: owns the program counter and drives the synchronous ROM.

---
 rtl/instr_fetch_if.sv | 26 ++
 rtl/instr_fetch.sv | 71 +++++++
 tb/tb_instr_fetch.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: ROM port, decoder control inputs and instruction outputs.
// master = fetch stage, slave = ROM/decoder side.
interface instr_fetch_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 24
);
    logic [PC_W-1:0]    rom_addr;
    logic               rom_rd_en;
    logic [INSTR_W-1:0] rom_q;
    logic               stall;
    logic               jump_enable;
    logic [PC_W-1:0]    jump_addr;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic [PC_W-1:0]    pc_out;

    modport master (
        output rom_addr, rom_rd_en, instr, instr_valid, pc_out,
        input  rom_q, stall, jump_enable, jump_addr
    );

    modport slave (
        input  rom_addr, rom_rd_en, instr, instr_valid, pc_out,
        output rom_q, stall, jump_enable, jump_addr
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: owns PC, drives sync ROM, squashes wrong-path words.
// Ports: clk, rst_n (sync, active low), bus (instr_fetch_if master).
module instr_fetch #(
    parameter int                  PC_W      = 8,
    parameter int                  INSTR_W   = 24,
    parameter logic [PC_W-1:0]     RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);
    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_FLUSH
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0] exec_pc_q, exec_pc_d;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        exec_pc_d  = exec_pc_q;
        if (!bus.stall) begin
            unique case (state_q)
                S_BOOT, S_FLUSH: begin
                    exec_pc_d  = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 1'b1;
                    state_d    = S_RUN;
                end
                S_RUN: begin
                    if (bus.jump_enable) begin
                        // read in flight for old fetch_pc is dropped
                        fetch_pc_d = bus.jump_addr;
                        state_d    = S_FLUSH;
                    end else begin
                        exec_pc_d  = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + 1'b1;
                    end
                end
                default: state_d = S_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_BOOT;
            fetch_pc_q <= RESET_PC;
            exec_pc_q  <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            exec_pc_q  <= exec_pc_d;
        end
    end

    // Outputs are forced to their idle values while rst_n is held low,
    // even before the first reset edge has cleared the registers.
    logic run;
    assign run = rst_n && (state_q == S_RUN);

    assign bus.rom_addr    = rst_n ? fetch_pc_q : RESET_PC;
    assign bus.rom_rd_en   = !bus.stall && rst_n;
    assign bus.instr       = run ? bus.rom_q : NOP_INSTR;
    assign bus.instr_valid = run;
    assign bus.pc_out      = rst_n ? exec_pc_q : RESET_PC;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural synchronous ROM.
module tb_instr_fetch;
    logic clk = 1'b0;
    logic rst_n;
    logic [23:0] mem [256];
    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instr_fetch_if #(.PC_W(8), .INSTR_W(24)) bus ();

    instr_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always @(posedge clk)
        if (bus.rom_rd_en) bus.rom_q <= mem[bus.rom_addr];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_run(input string tag, input logic [7:0] pc,
                           input logic [7:0] fa);
        check({tag, ".valid"}, 32'(bus.instr_valid), 32'd1);
        check({tag, ".pc"}, 32'(bus.pc_out), 32'(pc));
        check({tag, ".instr"}, 32'(bus.instr), 32'(mem[pc]));
        check({tag, ".addr"}, 32'(bus.rom_addr), 32'(fa));
    endtask

    task automatic exp_bubble(input string tag, input logic [7:0] fa);
        check({tag, ".valid"}, 32'(bus.instr_valid), 32'd0);
        check({tag, ".instr"}, 32'(bus.instr), 32'd0);
        check({tag, ".addr"}, 32'(bus.rom_addr), 32'(fa));
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            mem[i] = {8'(i), 8'(i ^ 8'h3C), 8'hA5};
        mem[0] = 24'h02_01_AA;
        mem[1] = 24'h05_01_00;
        bus.rom_q       = 24'h0;
        bus.stall       = 1'b0;
        bus.jump_enable = 1'b0;
        bus.jump_addr   = 8'h00;
        rst_n = 1'b0;
        step();
        step();
        check("rst.valid", 32'(bus.instr_valid), 32'd0);
        check("rst.instr", 32'(bus.instr), 32'd0);
        check("rst.rd_en", 32'(bus.rom_rd_en), 32'd0);
        check("rst.pc", 32'(bus.pc_out), 32'd0);
        check("rst.addr", 32'(bus.rom_addr), 32'd0);

        // boot
        rst_n = 1'b1;
        #1;
        check("boot0.valid", 32'(bus.instr_valid), 32'd0);
        check("boot0.addr", 32'(bus.rom_addr), 32'd0);
        check("boot0.rd_en", 32'(bus.rom_rd_en), 32'd1);
        step(); exp_run("boot1", 8'h00, 8'h01);
        step(); exp_run("boot2", 8'h01, 8'h02);
        step(); exp_run("lin2", 8'h02, 8'h03);
        step(); exp_run("lin3", 8'h03, 8'h04);

        // jump at pc=3 to 0x40
        bus.jump_enable = 1'b1;
        bus.jump_addr   = 8'h40;
        step(); exp_bubble("j40.bub", 8'h40);
        bus.jump_enable = 1'b0;
        step(); exp_run("j40.tgt", 8'h40, 8'h41);

        // jump to 5 for the stall test
        bus.jump_enable = 1'b1;
        bus.jump_addr   = 8'h05;
        step(); exp_bubble("j05.bub", 8'h05);
        bus.jump_enable = 1'b0;
        step(); exp_run("j05.tgt", 8'h05, 8'h06);

        // stall 3 cycles at pc=5
        bus.stall = 1'b1;
        #1;
        check("stall.rd_en", 32'(bus.rom_rd_en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            exp_run("stall.hold", 8'h05, 8'h06);
            check("stall.rd_en_h", 32'(bus.rom_rd_en), 32'd0);
        end
        bus.stall = 1'b0;
        step(); exp_run("stall.rel", 8'h06, 8'h07);

        // wrap at 0xFE
        bus.jump_enable = 1'b1;
        bus.jump_addr   = 8'hFE;
        step(); exp_bubble("jFE.bub", 8'hFE);
        bus.jump_enable = 1'b0;
        step(); exp_run("wrap.FE", 8'hFE, 8'hFF);
        step(); exp_run("wrap.FF", 8'hFF, 8'h00);
        step(); exp_run("wrap.00", 8'h00, 8'h01);

        // stall and jump together: stall wins
        bus.stall       = 1'b1;
        bus.jump_enable = 1'b1;
        bus.jump_addr   = 8'h20;
        step(); exp_run("sj.hold", 8'h00, 8'h01);
        bus.stall = 1'b0;
        step(); exp_bubble("sj.bub", 8'h20);
        bus.jump_enable = 1'b0;
        step(); exp_run("sj.tgt", 8'h20, 8'h21);

        // jump to next address still costs a bubble
        bus.jump_enable = 1'b1;
        bus.jump_addr   = 8'h21;
        step(); exp_bubble("jnx.bub", 8'h21);
        bus.jump_enable = 1'b0;
        step(); exp_run("jnx.tgt", 8'h21, 8'h22);

        // reset during flush
        bus.jump_enable = 1'b1;
        bus.jump_addr   = 8'h80;
        step(); exp_bubble("rf.bub", 8'h80);
        bus.jump_enable = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rf.rd_en", 32'(bus.rom_rd_en), 32'd0);
        check("rf.pc", 32'(bus.pc_out), 32'd0);
        step(); exp_bubble("rf.rst", 8'h00);
        rst_n = 1'b1;
        // jump during boot is ignored
        bus.jump_enable = 1'b1;
        bus.jump_addr   = 8'h77;
        #1;
        exp_bubble("rf.boot", 8'h00);
        step(); exp_run("rf.r0", 8'h00, 8'h01);
        bus.jump_enable = 1'b0;
        step(); exp_run("rf.r1", 8'h01, 8'h02);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
